path_gen: RTL and testbench

Binary-tree path walker. Starting from the root, it emits the heap-order index of each node visited as a root-to-leaf path is descended one level per accepted step. The left/right choice at each step comes from a direction bit. The address-generation logic instantiates it twice per path: once to walk subtrees, and once to walk buckets within the current subtree, where it is restarted at each subtree boundary. Output is a plain registered index with no handshake.

---
 rtl/path_gen_pkg.sv | 17 +
 rtl/path_gen.sv | 60 ++++++
 tb/tb_path_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/path_gen_pkg.sv
// -----------------------------------------------------------------------------
// path_gen_pkg
//   Shared definitions for the heap-order tree path walker.
//   - ORAML_DEFAULT : default tree depth (levels below the root).
//   - branch_offset : offset added to 2*i when descending from node i
//                     (left child 2i+1, right child 2i+2).
// -----------------------------------------------------------------------------
package path_gen_pkg;

    localparam int ORAML_DEFAULT = 32;

    // Dir = 0 picks the left child (+1), Dir = 1 the right child (+2).
    function automatic logic [1:0] branch_offset(input logic dir);
        return dir ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/path_gen.sv
// -----------------------------------------------------------------------------
// path_gen
//   Binary-tree path walker. Starting at the root (index 0) it descends one
//   level per accepted step and presents the heap-order index of the current
//   node. The left/right choice at each step comes from Dir.
//
// Parameters
//   ORAML   : tree depth in levels below the root; index is ORAML+1 bits.
//
// Ports
//   Clock   : in  1        rising-edge clock
//   Reset   : in  1        asynchronous, active-high; returns walker to root.
//                          Also pulsed synchronously by callers to restart.
//   Enable  : in  1        step qualifier
//   Switch  : in  1        descent permit; a step needs Enable && Switch
//   Dir     : in  1        0 = left child, 1 = right child (step cycles only)
//   BktIdx  : out ORAML+1  current node index (registered, no handshake)
//
// Index arithmetic is unsigned and wraps modulo 2^(ORAML+1); the caller is
// responsible for not stepping more than ORAML times per walk and for tracking
// the current depth.
// -----------------------------------------------------------------------------
module path_gen
    import path_gen_pkg::*;
#(
    parameter int ORAML = ORAML_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Switch,
    input  logic             Dir,
    output logic [ORAML:0]   BktIdx
);

    localparam int IDX_W = ORAML + 1;

    logic [IDX_W-1:0] idx;
    logic             step;

    // Heap-order child: 2*node + 1 + dir, truncated to the index width.
    function automatic logic [IDX_W-1:0] child_of(input logic [IDX_W-1:0] node,
                                                  input logic             dir);
        return (node << 1) + IDX_W'(branch_offset(dir));
    endfunction

    assign step = Enable & Switch;

    // ---- stage p0: node register (reset wins over a same-cycle step) ----
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx <= '0;
        end else if (step) begin
            idx <= child_of(idx, Dir);
        end
    end

    assign BktIdx = idx;

endmodule

// File: tb/tb_path_gen.sv
// -----------------------------------------------------------------------------
// tb_path_gen
//   Three walkers (ORAML = 3, 2 and default 32) share one stimulus stream.
//   The reference describes a walk by its step count k and the direction bits
//   read as a binary number; the expected index is 2^k - 1 + bits, reduced
//   modulo 2^(ORAML+1). Directed sequences with literal expectations pin the
//   reference, then randomized traffic runs against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_path_gen;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic        Switch;
    logic        Dir;
    logic [3:0]  idx3;
    logic [2:0]  idx2;
    logic [32:0] idx32;

    int errors = 0;
    int checks = 0;

    path_gen #(.ORAML(3)) u3 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .Switch(Switch), .Dir(Dir), .BktIdx(idx3)
    );

    path_gen #(.ORAML(2)) u2 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .Switch(Switch), .Dir(Dir), .BktIdx(idx2)
    );

    path_gen u32 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .Switch(Switch), .Dir(Dir), .BktIdx(idx32)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference walk state: number of steps taken and direction bits so far.
    int          m_k;
    logic [63:0] m_bits;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_k    <= 0;
            m_bits <= '0;
        end else if (Enable && Switch) begin
            if (m_k < 64) m_k <= m_k + 1;
            m_bits <= (m_bits << 1) | {63'd0, Dir};
        end
    end

    function automatic logic [63:0] model_idx(input int w);
        logic [63:0] full;
        logic [63:0] mask;
        full = ((m_k >= 64) ? 64'd0 : (64'd1 << m_k)) - 64'd1 + m_bits;
        mask = (64'd1 << w) - 64'd1;
        return full & mask;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the reference, away from the active edge.
    always @(negedge Clock) begin
        chk("model_o3",  {60'd0, idx3},  model_idx(4));
        chk("model_o2",  {61'd0, idx2},  model_idx(3));
        chk("model_o32", {31'd0, idx32}, model_idx(33));
    end

    // Apply inputs (called just after a rising edge), then wait for the
    // next rising edge and settle.
    task automatic cyc(input logic r, input logic e, input logic s, input logic d);
        Reset  = r;
        Enable = e;
        Switch = s;
        Dir    = d;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset  = 1'b1;
        Enable = 1'b0;
        Switch = 1'b0;
        Dir    = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_o3",  {60'd0, idx3},  64'd0);
        chk("reset_o32", {31'd0, idx32}, 64'd0);

        // Asynchronous reset in the middle of a walk.
        cyc(0, 1, 1, 1);  chk("async_pre1", {60'd0, idx3}, 64'd2);
        cyc(0, 1, 1, 1);  chk("async_pre2", {60'd0, idx3}, 64'd6);
        Enable = 1'b1; Switch = 1'b1; Dir = 1'b1;
        #2 Reset = 1'b1;
        #1 chk("async_clear", {60'd0, idx3}, 64'd0);
        @(posedge Clock); #1;
        chk("async_hold", {60'd0, idx3}, 64'd0);
        cyc(0, 0, 0, 0);  chk("after_release", {60'd0, idx3}, 64'd0);

        // All-left walk then hold.
        cyc(0, 1, 1, 0);  chk("left1", {60'd0, idx3}, 64'd1);
        cyc(0, 1, 1, 0);  chk("left2", {60'd0, idx3}, 64'd3);
        cyc(0, 1, 1, 0);  chk("left3", {60'd0, idx3}, 64'd7);
        cyc(0, 0, 1, 1);  chk("left_hold", {60'd0, idx3}, 64'd7);
        cyc(1, 0, 0, 0);

        // Mixed walk 1,0,1.
        cyc(0, 1, 1, 1);  chk("mixed1", {60'd0, idx3}, 64'd2);
        cyc(0, 1, 1, 0);  chk("mixed2", {60'd0, idx3}, 64'd5);
        cyc(0, 1, 1, 1);  chk("mixed3", {60'd0, idx3}, 64'd12);
        cyc(1, 0, 0, 0);

        // Switch gating.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1);
            chk("switch_gate", {60'd0, idx3}, 64'd0);
        end
        cyc(0, 1, 1, 1);  chk("switch_open", {60'd0, idx3}, 64'd2);
        cyc(1, 0, 0, 0);

        // Restart: reset wins over a same-cycle step.
        cyc(0, 1, 1, 1);  chk("restart1", {60'd0, idx3}, 64'd2);
        cyc(0, 1, 1, 1);  chk("restart2", {60'd0, idx3}, 64'd6);
        cyc(1, 1, 1, 1);  chk("restart_drop", {60'd0, idx3}, 64'd0);
        cyc(0, 1, 1, 0);  chk("restart_next", {60'd0, idx3}, 64'd1);
        cyc(1, 0, 0, 0);

        // Overflow wrap: four right steps on 3-bit and 4-bit walkers.
        cyc(0, 1, 1, 1);  chk("wrap2_1", {61'd0, idx2}, 64'd2);
        cyc(0, 1, 1, 1);  chk("wrap2_2", {61'd0, idx2}, 64'd6);
        cyc(0, 1, 1, 1);  chk("wrap2_3", {61'd0, idx2}, 64'd6);
        chk("wrap3_3", {60'd0, idx3}, 64'd14);
        cyc(0, 1, 1, 1);  chk("wrap2_4", {61'd0, idx2}, 64'd6);
        chk("wrap3_4", {60'd0, idx3}, 64'd14);
        chk("wide_4",  {31'd0, idx32}, 64'd30);
        cyc(1, 0, 0, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 31) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        @(negedge Clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
